featuremap_pad_writer: RTL and testbench
========================================

# featuremap_pad_writer

Producer side of the three-channel pixel FIFO that feeds the featuremap conv2d blocks. It takes an unpadded WIDTH×HEIGHT stream of packed B/G/R float32 pixels and writes the zero-padded (WIDTH+2)×(HEIGHT+2) frame into the FIFO, row-major, one word per write. The featuremap blocks size their line buffers for WIDTH+2 and read through rdreq/empty, and that sizing depends on this padding.

## Interface
- DATA_WIDTH, 32, width of one channel word (IEEE-754 single)
- WIDTH, 112, unpadded image width in pixels
- HEIGHT, 112, unpadded image height in pixels
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse that begins a frame; ignored while busy=1
- pix_in  input  3*DATA_WIDTH  packed pixel: [3DW-1:2DW]=B, [2DW-1:DW]=G, [DW-1:0]=R
- pix_valid  input  1  pix_in holds a valid pixel
- pix_ready  output  1  pixel consumed this cycle when pix_valid=1
- fifo_full  input  1  FIFO full flag; no write may be issued while high
- wrreq  output  1  FIFO write strobe; data_out is written on this edge
- data_out  output  3*DATA_WIDTH  FIFO write data, same packing as pix_in
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after the last padded word is written

## Operation
- States: IDLE, ACTIVE, DONE. Counters: row 0..HEIGHT+1, col 0..WIDTH+1, each $clog2 sized.
- IDLE: when start=1, row and col are cleared and the state moves to ACTIVE. busy=0.
- ACTIVE: busy=1. A position is a border position if row==0, row==HEIGHT+1, col==0 or col==WIDTH+1.
- Border position: wrreq = !fifo_full and data_out = 0. pix_ready=0.
- Interior position: wrreq = pix_valid & !fifo_full, data_out = pix_in, pix_ready = !fifo_full. A pixel is consumed if and only if it is written.
- On every write, col increments. When col==WIDTH+1, col wraps to 0 and row increments. A write at row==HEIGHT+1 and col==WIDTH+1 moves the state to DONE.
- DONE: frame_done=1 and busy=1 for one cycle, then the state returns to IDLE.
- Outside ACTIVE: wrreq=0, pix_ready=0, data_out=0.
- Each frame issues exactly (WIDTH+2)*(HEIGHT+2) writes and consumes exactly WIDTH*HEIGHT pixels.
- Output decode (wrreq, pix_ready, data_out) is combinational from state, counters, fifo_full and pix_valid. State and counters are registered.

## Timing
- Reset values: state=IDLE, row=col=0. wrreq=0, pix_ready=0, busy=0, frame_done=0, data_out=0.
- Reset is asynchronous. Asserting it mid-frame drops wrreq and pix_ready immediately and abandons the frame. No partial-frame recovery is provided.
- The first write can occur in the cycle after start, provided fifo_full=0.
- Throughput is one word per cycle when fifo_full=0 and pix_valid=1 at every interior position.
- fifo_full=1 freezes the counters and forces wrreq=0. The freeze is arbitrary length and may occur at any position, including the final one.
- pix_valid=0 at an interior position stalls the counters. It never causes a pad word to be written in place of the pixel.
- frame_done is high in the cycle after the final write. busy falls one cycle after that.
- A start pulse that coincides with the DONE cycle is ignored. start is accepted in IDLE only.

## Test plan
- WIDTH=4, HEIGHT=3, pix_valid held at 1, fifo_full=0, pixels numbered 1..12 in all channels. Required: 30 writes in 30 consecutive cycles. Words 0–5, 6, 11, 12, 17, 18, 23 and 24–29 are zero. Interior words are 1..12 in order. frame_done pulses once, in the cycle after word 29.
- Same frame with fifo_full toggled randomly. Required: wrreq is never high while fifo_full=1, and the written sequence is identical to the first test.
- Same frame with pix_valid deasserted for 3 cycles at interior position (row 2, col 1). Required: no writes during the gap, and the sequence is unchanged.
- Channel packing: pix_in = {B=32'h3F800000, G=32'h40000000, R=32'h40400000}. Required: data_out carries the same three fields at the same bit positions on the first interior write (word 7).
- rst pulsed low at word 15 of a frame, then start issued again. Required: outputs go to their reset values immediately, and the new frame begins with 6 zero words.
- start pulsed while busy=1, and again during the DONE cycle. Required: both pulses are ignored, and exactly one frame of 30 writes is produced.

Source files
------------

// File: rtl/featuremap_pad_writer.sv
// Producer for the featuremap pixel FIFO: wraps an unpadded WIDTH x HEIGHT B/G/R
// pixel stream in a one-pixel zero border and writes it row-major, one word per write.
module featuremap_pad_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3*DATA_WIDTH-1:0] pix_in,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic                    fifo_full,
    output logic                    wrreq,
    output logic [3*DATA_WIDTH-1:0] data_out,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int RW = $clog2(HEIGHT + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] row, row_nxt;
    logic [CW-1:0] col, col_nxt;
    logic          border;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        col_nxt    = col;
        wrreq      = 1'b0;
        pix_ready  = 1'b0;
        data_out   = '0;
        border     = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
        busy       = (state != IDLE);
        frame_done = (state == DONE);

        unique case (state)
            IDLE: begin
                if (start) begin
                    row_nxt   = '0;
                    col_nxt   = '0;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (border) begin
                    wrreq = !fifo_full;
                end else begin
                    // pix_ready tracks only fifo_full so a pixel is taken exactly when written
                    wrreq     = pix_valid && !fifo_full;
                    pix_ready = !fifo_full;
                    data_out  = pix_in;
                end
                if (wrreq) begin
                    if (col == COL_LAST) begin
                        col_nxt = '0;
                        if (row == ROW_LAST) state_nxt = DONE;
                        else                 row_nxt   = row + 1'b1;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Directed bench for featuremap_pad_writer on a 4x3 frame (6x5 padded, 30 writes).
module tb_featuremap_pad_writer;

    localparam int DW = 32;
    localparam logic [95:0] PACK = {32'h3F800000, 32'h40000000, 32'h40400000};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [95:0]   pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic          fifo_full = 1'b0;
    logic          wrreq;
    logic [95:0]   data_out;
    logic          busy;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    int          cur_mode;
    int          nwr;
    logic [31:0] pix_num;
    int          done_cnt;
    int          cyc_n;
    int          first_wr_cyc;
    int          last_wr_cyc;
    int          done_cyc;

    featuremap_pad_writer #(
        .DATA_WIDTH(DW),
        .WIDTH     (4),
        .HEIGHT    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .fifo_full (fifo_full),
        .wrreq     (wrreq),
        .data_out  (data_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Padded word k of the 6x5 frame; interior pixels are numbered 1..12 row-major.
    function automatic logic [95:0] exp_word(input int k, input int mode);
        int r, c;
        logic [31:0] n;
        r = k / 6;
        c = k % 6;
        if (r == 0 || r == 4 || c == 0 || c == 5) return '0;
        if (mode == 3) return PACK;
        n = 32'((r - 1) * 4 + c);
        return {n, n, n};
    endfunction

    task automatic cyc(input logic s, input logic v, input logic f);
        @(negedge clk);
        start     = s;
        pix_valid = v;
        fifo_full = f;
        pix_in    = (cur_mode == 3) ? PACK : {pix_num, pix_num, pix_num};
        #1;
        if (f) check("no_wr_when_full", {95'd0, wrreq}, 96'd0);
        if (pix_ready && pix_valid) check("consume_iff_write", {95'd0, wrreq}, 96'd1);
        if (wrreq) begin
            if (nwr < 30) check("word", data_out, exp_word(nwr, cur_mode));
            else          check("extra_write", 96'(nwr), 96'd29);
            if (cur_mode == 3 && nwr == 7) begin
                check("pack_b", {64'd0, data_out[95:64]}, {64'd0, 32'h3F800000});
                check("pack_g", {64'd0, data_out[63:32]}, {64'd0, 32'h40000000});
                check("pack_r", {64'd0, data_out[31:0]},  {64'd0, 32'h40400000});
            end
            if (first_wr_cyc < 0) first_wr_cyc = cyc_n;
            last_wr_cyc = cyc_n;
            nwr++;
        end
        if (pix_ready && pix_valid) pix_num++;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        cyc_n++;
    endtask

    // mode: 0 plain, 1 random fifo_full, 2 pix_valid gap, 3 packing, 4 reset at word 15, 5 start spam
    task automatic run_frame(input int mode);
        int unsigned gap;
        logic s, v, f;
        cur_mode     = mode;
        nwr          = 0;
        pix_num      = 32'd1;
        done_cnt     = 0;
        cyc_n        = 0;
        first_wr_cyc = -1;
        last_wr_cyc  = -1;
        done_cyc     = -1;
        gap          = 0;
        cyc(1'b1, 1'b1, 1'b0);
        check("idle_busy", {95'd0, busy}, 96'd0);
        for (int unsigned b = 0; b < 400 && done_cnt == 0; b++) begin
            s = 1'b0;
            v = 1'b1;
            f = 1'b0;
            if (mode == 1) f = 1'($urandom_range(0, 1));
            if (mode == 2 && nwr == 13 && gap < 3) begin
                v = 1'b0;
                gap++;
            end
            if (mode == 5 && (nwr == 10 || nwr == 30)) s = 1'b1;
            if (mode == 4 && nwr == 15) begin
                @(negedge clk);
                pix_valid = 1'b1;
                fifo_full = 1'b0;
                rst       = 1'b0;
                #1;
                check("rst_wrreq",      {95'd0, wrreq},      96'd0);
                check("rst_pix_ready",  {95'd0, pix_ready},  96'd0);
                check("rst_busy",       {95'd0, busy},       96'd0);
                check("rst_frame_done", {95'd0, frame_done}, 96'd0);
                check("rst_data_out",   data_out,            96'd0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            cyc(s, v, f);
            if (mode == 1) check("busy_active", {95'd0, busy}, 96'd1);
            if (mode == 2 && !v) check("gap_no_wr", {95'd0, wrreq}, 96'd0);
        end
        check("frame_finished", 96'(done_cnt), 96'd1);
        check("write_count", 96'(nwr), 96'd30);
        check("pixel_count", 96'(pix_num), 96'd13);
        check("done_after_last", 96'(done_cyc - last_wr_cyc), 96'd1);
        if (mode == 0) begin
            check("first_wr_cycle", 96'(first_wr_cyc), 96'd1);
            check("consecutive", 96'(last_wr_cyc - first_wr_cyc + 1), 96'd30);
        end
        cyc(1'b0, 1'b1, 1'b0);
        check("busy_fall", {95'd0, busy}, 96'd0);
        check("done_single", {95'd0, frame_done}, 96'd0);
        if (mode == 5) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cyc(1'b0, 1'b1, 1'b0);
                check("no_second_frame", {95'd0, wrreq}, 96'd0);
            end
            check("spam_total_writes", 96'(nwr), 96'd30);
        end
    endtask

    initial begin
        cur_mode = 0;
        pix_num  = 32'd1;
        nwr      = 0;
        #2;
        check("reset_wrreq",      {95'd0, wrreq},      96'd0);
        check("reset_pix_ready",  {95'd0, pix_ready},  96'd0);
        check("reset_busy",       {95'd0, busy},       96'd0);
        check("reset_frame_done", {95'd0, frame_done}, 96'd0);
        check("reset_data_out",   data_out,            96'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        check("idle_no_wr", {95'd0, wrreq}, 96'd0);

        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(3);
        run_frame(4);
        run_frame(0);
        run_frame(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
